// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants for the 16-bit five-stage CPU
//
// Purpose: datapath widths, ALU opcode encodings, EX operand forwarding
//          selects, and a saturating-increment helper used by debug counters.
// Ports:   none (package)
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  // ALU opcodes carried on id_alu_op / ex_alu_op
  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_SLL   = 4'h5;
  localparam logic [3:0] ALU_SRL   = 4'h6;
  localparam logic [3:0] ALU_SLT   = 4'h7;
  localparam logic [3:0] ALU_PASSB = 4'h8;

  // EX operand mux selects
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - combinational forwarding select for one EX operand
//
// Purpose: picks which pipeline stage supplies an operand once it reaches EX.
//          The instruction now in EX will sit in EX/MEM next cycle, the one in
//          MEM will sit in MEM/WB; the nearer producer wins.
// Ports:
//   src, uses                      operand register ID and whether it is read
//   ex_valid/reg_write/mem_read/rd state of the instruction now in EX
//   mem_valid/reg_write/rd         state of the instruction now in MEM
//   sel                            2-bit select (RF / EX-MEM / MEM-WB)
module fwd_sel #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] src,
  input  logic             uses,
  input  logic             ex_valid,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_rd,
  output logic [1:0]       sel
);
  import cpu_pkg::*;

  always_comb begin
    sel = FWD_RF;
    // A load in EX cannot forward from EX/MEM; that case is a load-use bubble
    // and the operand is picked up from MEM/WB one cycle later.
    if (uses && ex_valid && ex_reg_write && !ex_mem_read && (ex_rd == src))
      sel = FWD_EXMEM;
    else if (uses && mem_valid && mem_reg_write && (mem_rd == src))
      sel = FWD_MEMWB;
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubbles and forwarding
//
// Purpose: registers the decoded instruction and register-file data into EX,
//          inserts one bubble on a load-use hazard, precomputes EX operand
//          forwarding selects, honours hold/flush, and counts bubbles.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   hold, flush                    global freeze, branch squash
//   id_*                           decoded instruction from ID
//   mem_valid/reg_write/rd         writer currently in MEM
//   ex_*                           registered instruction presented to EX
//   stall_id                       combinational; freezes PC and IF/ID
//   bubble_cnt                     saturating count of load-use bubbles
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_src1,
  input  logic [DATA_W-1:0] id_src2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc2,
  input  logic [3:0]        id_alu_op,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [REG_W-1:0]  mem_rd,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_src1,
  output logic [DATA_W-1:0] ex_src2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc2,
  output logic [3:0]        ex_alu_op,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b,
  output logic              stall_id,
  output logic [15:0]       bubble_cnt
);
  import cpu_pkg::*;

  logic       load_use;
  logic [1:0] fwd_a_nxt;
  logic [1:0] fwd_b_nxt;

  assign load_use = ex_valid & ex_mem_read & id_valid &
                    ((id_uses_rs & (id_rs == ex_rd)) |
                     (id_uses_rt & (id_rt == ex_rd)));

  // A flush kills the dependent instruction anyway, so no stall is needed.
  assign stall_id = hold | (load_use & ~flush);

  fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .src          (id_rs),
    .uses         (id_uses_rs),
    .ex_valid     (ex_valid),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .mem_valid    (mem_valid),
    .mem_reg_write(mem_reg_write),
    .mem_rd       (mem_rd),
    .sel          (fwd_a_nxt)
  );

  fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .src          (id_rt),
    .uses         (id_uses_rt),
    .ex_valid     (ex_valid),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .mem_valid    (mem_valid),
    .mem_reg_write(mem_reg_write),
    .mem_rd       (mem_rd),
    .sel          (fwd_b_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_src1      <= '0;
      ex_src2      <= '0;
      ex_imm       <= '0;
      ex_pc2       <= '0;
      ex_alu_op    <= '0;
      ex_fwd_a     <= FWD_RF;
      ex_fwd_b     <= FWD_RF;
      bubble_cnt   <= '0;
    end else if (!hold) begin
      // Data and IDs always follow ID; they are meaningless when ex_valid=0.
      ex_rs   <= id_rs;
      ex_rt   <= id_rt;
      ex_rd   <= id_rd;
      ex_src1 <= id_src1;
      ex_src2 <= id_src2;
      ex_imm  <= id_imm;
      ex_pc2  <= id_pc2;
      if (flush || load_use) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
        ex_alu_op    <= '0;
        ex_fwd_a     <= FWD_RF;
        ex_fwd_b     <= FWD_RF;
        if (!flush)
          bubble_cnt <= sat_inc16(bubble_cnt);
      end else begin
        ex_valid     <= id_valid;
        ex_reg_write <= id_reg_write & id_valid;
        ex_mem_read  <= id_mem_read & id_valid;
        ex_mem_write <= id_mem_write & id_valid;
        ex_alu_op    <= id_alu_op;
        ex_fwd_a     <= fwd_a_nxt;
        ex_fwd_b     <= fwd_b_nxt;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, hold, flush;
  logic        id_valid, id_uses_rs, id_uses_rt;
  logic [3:0]  id_rs, id_rt, id_rd, id_alu_op;
  logic [15:0] id_src1, id_src2, id_imm, id_pc2;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        mem_valid, mem_reg_write;
  logic [3:0]  mem_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [3:0]  ex_rs, ex_rt, ex_rd, ex_alu_op;
  logic [15:0] ex_src1, ex_src2, ex_imm, ex_pc2;
  logic [1:0]  ex_fwd_a, ex_fwd_b;
  logic        stall_id;
  logic [15:0] bubble_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(16), .REG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_src1(id_src1), .id_src2(id_src2), .id_imm(id_imm), .id_pc2(id_pc2),
    .id_alu_op(id_alu_op), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_imm(ex_imm), .ex_pc2(ex_pc2),
    .ex_alu_op(ex_alu_op), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
    .stall_id(stall_id), .bubble_cnt(bubble_cnt)
  );

  typedef struct packed {
    logic        v, rw, mr, mw;
    logic [3:0]  alu, rs, rt, rd;
    logic [15:0] s1, s2, imm, pc2;
    logic [1:0]  fa, fb;
    logic [15:0] cnt;
  } ex_state_t;

  ex_state_t m;
  ex_state_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [3:0] src, input logic uses);
    if (uses && m.v && m.rw && !m.mr && m.rd == src) return FWD_EXMEM;
    if (uses && mem_valid && mem_reg_write && mem_rd == src) return FWD_MEMWB;
    return FWD_RF;
  endfunction

  task automatic cmp_ex(input ex_state_t e);
    chk("ex_valid", 64'(ex_valid), 64'(e.v));
    chk("ex_ctrl", 64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op}),
        64'({e.rw, e.mr, e.mw, e.alu}));
    chk("ex_fwd", 64'({ex_fwd_a, ex_fwd_b}), 64'({e.fa, e.fb}));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(e.cnt));
    if (e.v) begin
      chk("ex_ids", 64'({ex_rs, ex_rt, ex_rd}), 64'({e.rs, e.rt, e.rd}));
      chk("ex_data", {ex_src1, ex_src2, ex_imm, ex_pc2}, {e.s1, e.s2, e.imm, e.pc2});
    end
  endtask

  // Called with inputs already driven (posedge+1); predicts, clocks, compares.
  task automatic step();
    ex_state_t n;
    logic lu;
    #1;
    lu = m.v & m.mr & id_valid &
         ((id_uses_rs & (id_rs == m.rd)) | (id_uses_rt & (id_rt == m.rd)));
    chk("stall_id", 64'(stall_id), 64'(hold | (lu & ~flush)));
    n = m;
    if (!hold) begin
      n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
      n.s1 = id_src1; n.s2 = id_src2; n.imm = id_imm; n.pc2 = id_pc2;
      if (flush || lu) begin
        n.v = 1'b0; n.rw = 1'b0; n.mr = 1'b0; n.mw = 1'b0;
        n.alu = 4'h0; n.fa = FWD_RF; n.fb = FWD_RF;
        if (!flush && m.cnt != 16'hFFFF) n.cnt = m.cnt + 16'd1;
      end else begin
        n.v  = id_valid;
        n.rw = id_reg_write & id_valid;
        n.mr = id_mem_read & id_valid;
        n.mw = id_mem_write & id_valid;
        n.alu = id_alu_op;
        n.fa = exp_fwd(id_rs, id_uses_rs);
        n.fb = exp_fwd(id_rt, id_uses_rt);
      end
    end
    sb.push_back(n);
    @(posedge clk);
    #1;
    m = sb.pop_front();
    cmp_ex(m);
  endtask

  task automatic set_id(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                        input logic [3:0] rd, input logic urs, input logic urt,
                        input logic rw, input logic mr, input logic mw,
                        input logic [3:0] alu, input logic [15:0] s1, input logic [15:0] s2);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = urs; id_uses_rt = urt;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    id_alu_op = alu; id_src1 = s1; id_src2 = s2;
    id_imm = s1 ^ 16'h5A5A; id_pc2 = s2 + 16'd2;
  endtask

  task automatic set_mem(input logic v, input logic rw, input logic [3:0] rd);
    mem_valid = v; mem_reg_write = rw; mem_rd = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cnt_before;
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 16'h0, 16'h0);
    set_mem(0, 0, 4'h0);
    m = '0;
    #12;
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_cnt", 64'(bubble_cnt), 64'd0);
    chk("rst_fwd", 64'({ex_fwd_a, ex_fwd_b}), 64'd0);
    chk("rst_stall", 64'(stall_id), 64'd0);
    hold = 1'b1;
    #1 chk("rst_stall_hold", 64'(stall_id), 64'd1);
    hold = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step();

    // Pass-through ADD r5 = r3 + r4
    set_id(1, 3, 4, 5, 1, 1, 1, 0, 0, ALU_ADD, 16'h1234, 16'h00FF);
    step();
    chk("pt_src1", 64'(ex_src1), 64'h1234);
    chk("pt_rd", 64'(ex_rd), 64'd5);
    chk("pt_rw", 64'(ex_reg_write), 64'd1);
    chk("pt_fwd", 64'({ex_fwd_a, ex_fwd_b}), 64'd0);

    // Load-use: LW r2 then ADD reading r2
    set_id(1, 1, 0, 2, 1, 0, 1, 1, 0, ALU_ADD, 16'h0010, 16'h0);
    step();
    set_mem(1, 1, 4'd5);
    set_id(1, 2, 4, 6, 1, 1, 1, 0, 0, ALU_ADD, 16'hAAAA, 16'h5555);
    #1 chk("lu_stall", 64'(stall_id), 64'd1);
    step();
    chk("lu_bubble", 64'(ex_valid), 64'd0);
    chk("lu_cnt", 64'(bubble_cnt), 64'd1);
    set_mem(1, 1, 4'd2);
    step();
    chk("lu_enter", 64'(ex_valid), 64'd1);
    chk("lu_fwd_a", 64'(ex_fwd_a), 64'(FWD_MEMWB));

    // Forwarding priority on r7 read as rt
    set_mem(0, 0, 4'd0);
    set_id(1, 1, 1, 7, 1, 1, 1, 0, 0, ALU_OR, 16'h1, 16'h2);
    step();
    set_mem(1, 1, 4'd7);
    set_id(1, 0, 7, 8, 0, 1, 1, 0, 0, ALU_SUB, 16'h3, 16'h4);
    step();
    chk("prio_exmem", 64'(ex_fwd_b), 64'(FWD_EXMEM));
    step();
    chk("prio_memwb", 64'(ex_fwd_b), 64'(FWD_MEMWB));
    id_uses_rt = 1'b0;
    step();
    chk("prio_unused", 64'(ex_fwd_b), 64'(FWD_RF));
    set_mem(0, 0, 4'd0);

    // Load followed by independent / non-reading instructions: no stall
    set_id(1, 1, 0, 9, 1, 0, 1, 1, 0, ALU_ADD, 16'h20, 16'h0);
    step();
    set_id(1, 3, 4, 10, 1, 1, 1, 0, 0, ALU_AND, 16'h7, 16'h8);
    step();
    chk("nodep_valid", 64'(ex_valid), 64'd1);
    set_id(1, 1, 0, 9, 1, 0, 1, 1, 0, ALU_ADD, 16'h20, 16'h0);
    step();
    set_id(1, 9, 9, 11, 0, 0, 1, 0, 1, ALU_XOR, 16'h9, 16'hA);
    step();
    chk("nouse_valid", 64'(ex_valid), 64'd1);

    // Flush versus hold
    set_id(1, 1, 2, 3, 1, 1, 1, 0, 0, ALU_ADD, 16'h11, 16'h22);
    flush = 1'b1;
    step();
    chk("flush_valid", 64'(ex_valid), 64'd0);
    flush = 1'b0;
    step();
    hold = 1'b1; flush = 1'b1;
    set_id(1, 4, 5, 6, 1, 1, 1, 1, 0, ALU_SLT, 16'h33, 16'h44);
    step();
    chk("hold_keep", 64'({ex_valid, ex_src1}), 64'({1'b1, 16'h11}));
    hold = 1'b0;
    step();
    chk("flush_after_hold", 64'(ex_valid), 64'd0);
    flush = 1'b0;

    // Hold during a load-use hazard does not count a bubble
    set_id(1, 1, 0, 2, 1, 0, 1, 1, 0, ALU_ADD, 16'h10, 16'h0);
    step();
    cnt_before = bubble_cnt;
    set_id(1, 2, 2, 3, 1, 1, 1, 0, 0, ALU_ADD, 16'h1, 16'h1);
    hold = 1'b1;
    step();
    chk("hold_hazard_cnt", 64'(bubble_cnt), 64'(cnt_before));
    hold = 1'b0;
    step();
    chk("hazard_after_hold", 64'(bubble_cnt), 64'(cnt_before + 16'd1));
    step();

    // Random traffic over a small register set to provoke hazards
    for (int i = 0; i < 300; i++) begin
      set_id(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 8)),
             16'($urandom), 16'($urandom));
      set_mem(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 3)));
      hold  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      step();
    end
    hold = 1'b0; flush = 1'b0;
    set_mem(0, 0, 4'd0);

    // Saturation: preload near the top, then drive repeated load-use bubbles
    force dut.bubble_cnt = 16'hFFFD;
    #1 release dut.bubble_cnt;
    m.cnt = 16'hFFFD;
    chk("sat_preload", 64'(bubble_cnt), 64'hFFFD);
    set_id(1, 2, 0, 2, 1, 0, 1, 1, 0, ALU_ADD, 16'h40, 16'h0);
    for (int i = 0; i < 10; i++) step();
    chk("sat_hold_ffff", 64'(bubble_cnt), 64'hFFFF);

    // Asynchronous reset mid-cycle
    set_id(1, 3, 4, 5, 1, 1, 1, 0, 0, ALU_ADD, 16'h1234, 16'h00FF);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ex_valid), 64'd0);
    chk("arst_src1", 64'(ex_src1), 64'd0);
    chk("arst_cnt", 64'(bubble_cnt), 64'd0);
    chk("arst_stall", 64'(stall_id), 64'd0);
    m = '0;
    @(negedge clk) rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
